// File: rtl/hpdcache_core_rsp_buf_pkg.sv
// Shared types for the core response buffer slice: cache configuration
// record and the legal depth bound for the response FIFO.
package hpdcache_core_rsp_buf_pkg;

    typedef struct packed {
        logic [7:0] nRequesters;
        logic [7:0] rspBufDepth;
    } hpdcache_cfg_t;

    localparam int unsigned HPDCACHE_RSP_BUF_MAX_DEPTH = 16;

endpackage

// File: rtl/hpdcache_core_rsp_buf_fifo_ctrl.sv
// FIFO bookkeeping: write/read pointers with non-power-of-two wrap and an
// occupancy counter. Storage lives in the instantiating module.
module hpdcache_fifo_ctrl
    import hpdcache_core_rsp_buf_pkg::*;
#(
    parameter int unsigned Depth    = 2,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned OccWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                store_i,
    input  logic                pop_i,
    output logic [PtrWidth-1:0] wptr_o,
    output logic [PtrWidth-1:0] rptr_o,
    output logic [OccWidth-1:0] occupancy_o,
    output logic                full_o,
    output logic                empty_o
);

    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic [OccWidth-1:0] occ_q, occ_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (store_i) wptr_d = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        if (pop_i)   rptr_d = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        if (store_i && !pop_i)      occ_d = occ_q + 1'b1;
        else if (!store_i && pop_i) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    assign wptr_o      = wptr_q;
    assign rptr_o      = rptr_q;
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == OccWidth'(Depth));
    assign empty_o     = (occ_q == '0);

    a_depth_legal: assert property (@(posedge clk_i)
        (Depth >= 1) && (Depth <= HPDCACHE_RSP_BUF_MAX_DEPTH));
    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        occ_q <= OccWidth'(Depth));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(store_i && !pop_i && full_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));

endmodule

// File: rtl/hpdcache_core_rsp_buf.sv
// Per-requester response buffer between the bank crossbar and a requester,
// with optional fall-through when empty and occupancy reporting.
module hpdcache_core_rsp_buf
    import hpdcache_core_rsp_buf_pkg::*;
#(
    parameter hpdcache_cfg_t HPDcacheCfg    = '0,
    parameter type           hpdcache_rsp_t = logic,
    parameter int unsigned   Depth          = 2,
    parameter bit            FallThrough    = 1'b0,
    localparam int unsigned  OccWidth       = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    input  hpdcache_rsp_t       rsp_i,
    output logic                core_rsp_valid_o,
    input  logic                core_rsp_ready_i,
    output hpdcache_rsp_t       core_rsp_o,
    output logic [OccWidth-1:0] occupancy_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    hpdcache_rsp_t       mem_q [Depth];
    logic [PtrWidth-1:0] wptr, rptr;
    logic                push, store, pop_stor;

    hpdcache_fifo_ctrl #(
        .Depth (Depth)
    ) i_fifo_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .store_i     (store),
        .pop_i       (pop_stor),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .occupancy_o (occupancy_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    assign rsp_ready_o = !full_o;
    assign push        = rsp_valid_i & rsp_ready_o;

    // In fall-through mode a response consumed while the buffer is empty
    // goes straight to the requester and never touches storage.
    always_comb begin
        core_rsp_valid_o = !empty_o;
        core_rsp_o       = mem_q[rptr];
        store            = push;
        pop_stor         = !empty_o & core_rsp_ready_i;
        if (FallThrough) begin
            core_rsp_valid_o = !empty_o | rsp_valid_i;
            core_rsp_o       = empty_o ? rsp_i : mem_q[rptr];
            store            = push & !(empty_o & core_rsp_ready_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem_q[wptr] <= rsp_i;
    end

endmodule

// File: tb/tb_hpdcache_core_rsp_buf.sv
// Directed bench for hpdcache_core_rsp_buf across three configurations:
// Depth=2 FT=0 (a_*), Depth=3 FT=0 (b_*), Depth=2 FT=1 (c_*).
module tb_hpdcache_core_rsp_buf;
    import hpdcache_core_rsp_buf_pkg::*;

    typedef logic [15:0] rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic a_vld, a_irdy, a_ovld, a_rdy, a_full, a_empty;
    rsp_t a_data, a_odata;
    logic [1:0] a_occ;
    logic b_vld, b_irdy, b_ovld, b_rdy, b_full, b_empty;
    rsp_t b_data, b_odata;
    logic [1:0] b_occ;
    logic c_vld, c_irdy, c_ovld, c_rdy, c_full, c_empty;
    rsp_t c_data, c_odata;
    logic [1:0] c_occ;

    hpdcache_core_rsp_buf #(
        .HPDcacheCfg ('0), .hpdcache_rsp_t (rsp_t), .Depth (2), .FallThrough (1'b0)
    ) u_d2 (
        .clk_i (clk), .rst_ni (rst_n),
        .rsp_valid_i (a_vld), .rsp_ready_o (a_irdy), .rsp_i (a_data),
        .core_rsp_valid_o (a_ovld), .core_rsp_ready_i (a_rdy), .core_rsp_o (a_odata),
        .occupancy_o (a_occ), .full_o (a_full), .empty_o (a_empty)
    );

    hpdcache_core_rsp_buf #(
        .HPDcacheCfg ('0), .hpdcache_rsp_t (rsp_t), .Depth (3), .FallThrough (1'b0)
    ) u_d3 (
        .clk_i (clk), .rst_ni (rst_n),
        .rsp_valid_i (b_vld), .rsp_ready_o (b_irdy), .rsp_i (b_data),
        .core_rsp_valid_o (b_ovld), .core_rsp_ready_i (b_rdy), .core_rsp_o (b_odata),
        .occupancy_o (b_occ), .full_o (b_full), .empty_o (b_empty)
    );

    hpdcache_core_rsp_buf #(
        .HPDcacheCfg ('0), .hpdcache_rsp_t (rsp_t), .Depth (2), .FallThrough (1'b1)
    ) u_ft (
        .clk_i (clk), .rst_ni (rst_n),
        .rsp_valid_i (c_vld), .rsp_ready_o (c_irdy), .rsp_i (c_data),
        .core_rsp_valid_o (c_ovld), .core_rsp_ready_i (c_rdy), .core_rsp_o (c_odata),
        .occupancy_o (c_occ), .full_o (c_full), .empty_o (c_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       vld;
        rsp_t       data;
        logic       rdy;
        logic       e_vld;
        rsp_t       e_data;
        logic [1:0] e_occ;
        logic       e_full;
        logic       e_empty;
        logic       e_irdy;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Depth=2 FT=0: fill, full with blocked push, pop-while-full, drain.
        vecs[0] = '{1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 16'h1A11, 1'b0, 1'b1, 16'h0A00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h2A22, 1'b0, 1'b1, 16'h0A00, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h2A22, 1'b1, 1'b1, 16'h0A00, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h2A22, 1'b0, 1'b1, 16'h1A11, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1A11, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h2A22, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1};

        a_vld = 1'b0; a_data = '0; a_rdy = 1'b0;
        b_vld = 1'b0; b_data = '0; b_rdy = 1'b0;
        c_vld = 1'b0; c_data = '0; c_rdy = 1'b0;

        #1;
        check("rst_a_occ",   32'(a_occ),   32'd0);
        check("rst_a_ovld",  32'(a_ovld),  32'd0);
        check("rst_a_irdy",  32'(a_irdy),  32'd1);
        check("rst_a_empty", 32'(a_empty), 32'd1);
        check("rst_a_full",  32'(a_full),  32'd0);
        check("rst_b_ovld",  32'(b_ovld),  32'd0);
        check("rst_c_ovld",  32'(c_ovld),  32'd0);
        check("rst_c_irdy",  32'(c_irdy),  32'd1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_a_occ",   32'(a_occ),   32'd0);
        check("idle_a_ovld",  32'(a_ovld),  32'd0);
        check("idle_a_irdy",  32'(a_irdy),  32'd1);
        check("idle_a_empty", 32'(a_empty), 32'd1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_vld = vecs[i].vld; a_data = vecs[i].data; a_rdy = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_ovld", i),  32'(a_ovld),  32'(vecs[i].e_vld));
            if (vecs[i].e_vld)
                check($sformatf("v%0d_data", i), 32'(a_odata), 32'(vecs[i].e_data));
            check($sformatf("v%0d_occ", i),   32'(a_occ),   32'(vecs[i].e_occ));
            check($sformatf("v%0d_full", i),  32'(a_full),  32'(vecs[i].e_full));
            check($sformatf("v%0d_empty", i), 32'(a_empty), 32'(vecs[i].e_empty));
            check($sformatf("v%0d_irdy", i),  32'(a_irdy),  32'(vecs[i].e_irdy));
        end

        // Depth=3 streaming, requester always ready.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_vld = 1'b1; b_data = 16'h3000 + 16'(i); b_rdy = 1'b1;
            #1;
            check($sformatf("s%0d_irdy", i), 32'(b_irdy), 32'd1);
            if (i == 0) begin
                check("s0_ovld", 32'(b_ovld), 32'd0);
                check("s0_occ",  32'(b_occ),  32'd0);
            end else begin
                check($sformatf("s%0d_ovld", i), 32'(b_ovld),  32'd1);
                check($sformatf("s%0d_data", i), 32'(b_odata), 32'(16'h3000 + 16'(i - 1)));
                check($sformatf("s%0d_occ", i),  32'(b_occ),   32'd1);
            end
        end
        @(negedge clk);
        b_vld = 1'b0;
        #1;
        check("s_last_ovld", 32'(b_ovld),  32'd1);
        check("s_last_data", 32'(b_odata), 32'h3009);
        @(negedge clk);
        #1;
        check("s_end_empty", 32'(b_empty), 32'd1);
        check("s_end_ovld",  32'(b_ovld),  32'd0);
        b_rdy = 1'b0;

        // Fall-through bypass while empty.
        @(negedge clk);
        c_vld = 1'b1; c_data = 16'h5A5A; c_rdy = 1'b1;
        #1;
        check("ft_byp_ovld", 32'(c_ovld),  32'd1);
        check("ft_byp_data", 32'(c_odata), 32'h5A5A);
        check("ft_byp_occ",  32'(c_occ),   32'd0);
        @(negedge clk);
        c_vld = 1'b0;
        #1;
        check("ft_after_occ",   32'(c_occ),   32'd0);
        check("ft_after_empty", 32'(c_empty), 32'd1);
        check("ft_after_ovld",  32'(c_ovld),  32'd0);
        // Fall-through visible but stalled: must be stored.
        c_vld = 1'b1; c_data = 16'h6B6B; c_rdy = 1'b0;
        #1;
        check("ft_stall_ovld", 32'(c_ovld),  32'd1);
        check("ft_stall_data", 32'(c_odata), 32'h6B6B);
        @(negedge clk);
        c_vld = 1'b0; c_data = 16'h0000; c_rdy = 1'b1;
        #1;
        check("ft_held_occ",  32'(c_occ),   32'd1);
        check("ft_held_data", 32'(c_odata), 32'h6B6B);
        @(negedge clk);
        c_rdy = 1'b0;
        #1;
        check("ft_drain_empty", 32'(c_empty), 32'd1);

        // Reset asserted mid-cycle with the buffer full.
        @(negedge clk);
        a_vld = 1'b1; a_data = 16'h7001; a_rdy = 1'b0;
        @(negedge clk);
        a_data = 16'h7002;
        @(negedge clk);
        a_vld = 1'b0;
        #1;
        check("mr_pre_occ", 32'(a_occ), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_occ",   32'(a_occ),   32'd0);
        check("mr_ovld",  32'(a_ovld),  32'd0);
        check("mr_irdy",  32'(a_irdy),  32'd1);
        check("mr_empty", 32'(a_empty), 32'd1);
        check("mr_full",  32'(a_full),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_vld = 1'b1; a_data = 16'h8001;
        @(negedge clk);
        a_data = 16'h8002;
        #1;
        check("mr_first_ovld", 32'(a_ovld),  32'd1);
        check("mr_first_data", 32'(a_odata), 32'h8001);
        @(negedge clk);
        a_vld = 1'b0; a_rdy = 1'b1;
        #1;
        check("mr_pop0_data", 32'(a_odata), 32'h8001);
        @(negedge clk);
        #1;
        check("mr_pop1_data", 32'(a_odata), 32'h8002);
        @(negedge clk);
        a_rdy = 1'b0;
        #1;
        check("mr_end_empty", 32'(a_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
